mux_operand_stage: RTL
======================

Name: mux_operand_stage

Overview:
Two-stage valid/ready pipeline that sits directly upstream of the design's 2-to-1 mux stage.
- Accepts an operand and a select bit.
- Computes the mux's alternate operand, (a << 2) + 1, truncated to WIDTH.
- Presents registered in0/in1/sel to the downstream mux under a handshake.
- Keeps saturating status counters of selections and stall cycles.

Parameters:
WIDTH, 8, operand width in bits (>= 3)
CNT_W, 8, width of each status counter

Ports:
clk  input  1  single clock, all state on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  upstream offers a transaction
in_ready  output  1  stage accepts the transaction this cycle
in_a  input  WIDTH  primary operand
in_b  input  1  select request for the downstream mux
out_valid  output  1  mux_in0/mux_in1/mux_sel are valid
out_ready  input  1  downstream mux stage consumes this cycle
mux_in0  output  WIDTH  pass-through of in_a
mux_in1  output  WIDTH  ((in_a << 2) + 1) mod 2^WIDTH
mux_sel  output  1  registered in_b
sel_count  output  CNT_W  saturating count of delivered transactions with mux_sel=1
stall_count  output  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0

Behaviour:
- Reset (rst=1 at a clk edge):
  - All stage valid flags, data registers, mux_in0, mux_in1, mux_sel, sel_count and stall_count go to 0.
  - out_valid=0.
  - in_ready is combinational and reads 1 during and after reset.
  - In-flight data is discarded; reset mid-transfer drops it silently.
- Handshake:
  - A transfer occurs on any edge where valid && ready.
  - Sources must hold data and valid until ready.
  - Stage holds outputs stable while out_valid && !out_ready.
- Stage 1 (s1): registers in_a and in_b plus s1_valid on input transfer.
- Stage 2 (s2):
  - Registers mux_in0 = s1_a.
  - Registers mux_in1 = {s1_a[WIDTH-3:0], 2'b00} + 1; carry out discarded.
  - Registers mux_sel = s1_b.
  - out_valid = s2_valid.
- Ready chain (combinational, no bubbles at full throughput):
  - s2_ready = !s2_valid || out_ready
  - s1_ready = !s1_valid || s2_ready
  - in_ready = s1_ready
- Latency: 2 cycles. Data accepted at edge N appears with out_valid=1 after edge N+1 when no stall occurs. Throughput is 1 transfer/cycle.
- Simultaneous accept and drain in the same cycle on either stage: new data replaces old, and the valid flag stays 1.
- Full condition: both stages valid and out_ready=0 forces in_ready=0. Nothing is overwritten or dropped.
- Empty condition: out_valid=0, and mux outputs retain the last value. Consumers must ignore them.
- sel_count: increments on an output transfer with mux_sel=1. Saturates at 2^CNT_W-1, never wraps.
- stall_count: increments each cycle with out_valid && !out_ready. Saturates the same way.
- No combinational path from in_a/in_b to any output. The only comb paths are out_ready -> in_ready and in_valid -> nothing.

Decomposition:
- Shared package mux_stage_pkg holds:
  - WIDTH_DEFAULT and CNT_W_DEFAULT constants.
  - Function cal_next(a) returning (a<<2)+1 truncated, reused by the calc stage and by the bench's reference model.
- One natural sub-module, mux_stage_sat_counter (parameter CNT_W, inputs clk/rst/inc, output count), is instantiated twice.

Test Plan:
- Reset then single beat, WIDTH=8, in_a=0x03, in_b=1, out_ready=1:
  - Expect out_valid=1 two edges later with mux_in0=0x03, mux_in1=0x0D, mux_sel=1.
  - Expect sel_count=1 after that transfer.
- Truncation: in_a=0x40 -> mux_in1=0x01; in_a=0xFF -> mux_in1=0xFD.
- Backpressure:
  - Stream 0x01..0x05 with out_ready=0. Expect in_ready=0 after 2 accepts and outputs held at 0x01/0x05.
  - Release out_ready. Expect all 5 beats delivered in order with no loss or duplication.
  - Expect stall_count to equal the held cycles.
- Full throughput: in_valid=1 and out_ready=1 for 100 cycles with random data.
  - Expect one output per cycle after a 2-cycle fill.
  - Expect in_ready constantly 1 and every output to match the cal_next model.
- Reset mid-operation: assert rst with both stages full.
  - Next cycle expect out_valid=0, in_ready=1 and counters 0.
  - Subsequent beat 0x02 emerges alone as mux_in1=0x09.
- Saturation, CNT_W=4: deliver 20 beats with in_b=1.
  - Expect sel_count=15 and holding.
  - Likewise stall_count stops at 15 after 20 stall cycles.

Source files
------------

// File: rtl/mux_stage_pkg.sv
// Shared constants and the alternate-operand function for the mux operand stage.
// cal_next works at a fixed wide width; callers truncate to their own operand width.
package mux_stage_pkg;

    localparam int unsigned WIDTH_DEFAULT = 8;
    localparam int unsigned CNT_W_DEFAULT = 8;
    localparam int unsigned CALC_W        = 64;

    function automatic logic [CALC_W-1:0] cal_next(input logic [CALC_W-1:0] a);
        return (a << 2) + CALC_W'(1);
    endfunction

endpackage

// File: rtl/mux_stage_sat_counter.sv
// Saturating up-counter used for the stage's status counters.
// Holds at all-ones instead of wrapping.
module mux_stage_sat_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (inc && (count_q != '1)) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/mux_operand_stage.sv
// Two-stage valid/ready pipeline feeding the downstream 2-to-1 mux with in0, in1 = (a<<2)+1
// and a registered select, plus saturating selection and stall counters.
module mux_operand_stage
    import mux_stage_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT,
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic             in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] mux_in0,
    output logic [WIDTH-1:0] mux_in1,
    output logic             mux_sel,
    output logic [CNT_W-1:0] sel_count,
    output logic [CNT_W-1:0] stall_count
);

    logic             s1_valid_q;
    logic [WIDTH-1:0] s1_a_q;
    logic             s1_b_q;
    logic             s2_valid_q;
    logic [WIDTH-1:0] in0_q;
    logic [WIDTH-1:0] in1_q;
    logic             sel_q;

    logic             s1_ready;
    logic             s2_ready;
    logic             in_xfer;
    logic             s1_xfer;
    logic             out_xfer;
    logic [WIDTH-1:0] alt_a;

    // Ready chain lets a stage accept in the same cycle it drains, so no bubbles at full rate.
    assign s2_ready = !s2_valid_q || out_ready;
    assign s1_ready = !s1_valid_q || s2_ready;
    assign in_ready = s1_ready;

    assign in_xfer  = in_valid && s1_ready;
    assign s1_xfer  = s1_valid_q && s2_ready;
    assign out_xfer = s2_valid_q && out_ready;

    assign alt_a = WIDTH'(cal_next(CALC_W'(s1_a_q)));

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= 1'b0;
            s2_valid_q <= 1'b0;
            in0_q      <= '0;
            in1_q      <= '0;
            sel_q      <= 1'b0;
        end else begin
            if (s1_ready) begin
                s1_valid_q <= in_valid;
            end
            if (in_xfer) begin
                s1_a_q <= in_a;
                s1_b_q <= in_b;
            end
            if (s2_ready) begin
                s2_valid_q <= s1_valid_q;
            end
            // Data registers only load on a real transfer, so an empty stage keeps its last value.
            if (s1_xfer) begin
                in0_q <= s1_a_q;
                in1_q <= alt_a;
                sel_q <= s1_b_q;
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign mux_in0   = in0_q;
    assign mux_in1   = in1_q;
    assign mux_sel   = sel_q;

    mux_stage_sat_counter #(
        .CNT_W (CNT_W)
    ) u_sel_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (out_xfer && sel_q),
        .count (sel_count)
    );

    mux_stage_sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (s2_valid_q && !out_ready),
        .count (stall_count)
    );

endmodule
